pio_edge_irq_ctrl: RTL
======================

# pio_edge_irq_ctrl

Debounced, edge-capturing input-port controller with interrupt generation, an Avalon-MM slave in the HPS lightweight bridge address space. It synchronizes a narrow asynchronous input bus (push-buttons, DIP switches, sensor flags), filters bounce on a prescaled sample tick, and latches selected edges into a write-1-to-clear capture register. It drives a level interrupt to the HPS GIC, so software no longer polls a plain input PIO.

## Interface
Parameters:
- WIDTH, 4, number of input bits (1..32).
- DIV, 1000, sample-tick period in clk cycles (≥1).
- CNT, 4, consecutive ticks of a changed level required to accept it (1..15).

Ports:
- clk  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  asynchronous raw inputs.
- irq  out  1  level interrupt, active high.

## Operation
- Write occurs on a cycle with chipselect=1 and write_n=0.
- Register map (word addresses):
  - 0 DATA (RO): debounced inputs in [WIDTH-1:0]; writes ignored.
  - 1 IRQMASK (RW): per-bit interrupt enable.
  - 2 EDGEMODE (RW): [1:0]; 00 rising, 01 falling, 10 both, 11 none. Upper bits read 0.
  - 3 EDGECAP (R/W1C): captured edges; writing 1 clears that bit.
- Unused readdata bits read 0.
- Synchronizer: two flops per bit, reset 0, producing sync[i].
- Prescaler: counts 0..DIV-1 and wraps. tick=1 in the cycle the count equals DIV-1. With DIV=1, tick is 1 every cycle.
- Debounce, per bit, with a 4-bit counter c[i]:
  - If sync[i]==deb[i]: c[i] is cleared to 0.
  - Else, on a tick cycle: if c[i]==CNT-1, then deb[i]<=sync[i] and c[i]<=0; otherwise c[i] increments.
  - Any return of sync[i] to deb[i] before acceptance clears c[i], so the count restarts.
- Edge detect: prev[i] holds deb[i] delayed one cycle. rise = deb & ~prev; fall = ~deb & prev. The selected edge per EDGEMODE sets EDGECAP[i].
- Simultaneous W1C and a new edge on the same bit: set wins, and the bit stays 1.
- irq = |(EDGECAP & IRQMASK), decoded combinationally from registers.
- Changing IRQMASK or EDGEMODE never alters EDGECAP contents.

## Timing
- Reset values are all 0: readdata, irq, deb, prev, EDGECAP, IRQMASK, EDGEMODE (rising), prescaler, c[].
- Read latency is 1: readdata <= mux(address) on every clk edge, regardless of chipselect. A read coinciding with a write to the same register returns the pre-write value.
- Write effects are visible in the register on the next cycle; irq follows in that same cycle.
- Input path: in_port change → sync after 2 cycles → deb after CNT ticks of stable difference → EDGECAP set 1 cycle after deb changes → irq in the same cycle as EDGECAP.
- Worst-case debounce latency is 2 + CNT·DIV cycles.
- Reset asserted mid-debounce aborts the count; deb returns to 0 with no edge captured. After release, an input held at 1 is re-accepted and produces a rising edge.

## Configuration
- PIO_DEBOUNCE_EN defined: the debounce filter, prescaler and counters are implemented as above.
- Not defined: prescaler and counters are omitted, and deb[i] <= sync[i] every cycle. DIV and CNT are ignored. Total input-to-EDGECAP latency is 4 cycles, counted through deb, prev and the capture register.

## Test plan
- Reset, then read all four addresses → readdata 0 each, irq 0.
- DIV=4, CNT=3, EDGEMODE=00, IRQMASK=0x1, in_port[0] 0→1 held → DATA=0x1 no later than 2+12 cycles after the change; EDGECAP=0x1 one cycle later; irq=1 in the same cycle.
- Bounce: toggle in_port[1] every 5 cycles for 40 cycles, then hold 1 → deb[1] changes exactly once, EDGECAP=0x2; with IRQMASK=0, irq stays 0.
- EDGEMODE=10, in_port[2] 0→1→0 with each level held 20 cycles → EDGECAP[2] set after the rise. Write 0x4 to address 3 → cleared. Set again after the fall.
- W1C to address 3 in the exact cycle a new edge sets bit 0 → EDGECAP[0] remains 1 and irq remains 1.
- Assert reset_n=0 for 1 cycle midway through a debounce count with in_port=0xF → all registers 0. After release, DATA=0xF after 2+CNT·DIV cycles and EDGECAP=0xF (rising mode).

Source files
------------

// File: rtl/pio_edge_irq_ctrl.sv
// Edge-capturing input PIO with write-1-to-clear capture register and level irq.
// Define PIO_DEBOUNCE_EN to insert the prescaled debounce filter between synchronizer and edge detect.
module pio_edge_irq_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV   = 1000,
  parameter int CNT   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync1, sync2, deb, prev;
  logic [WIDTH-1:0] irqmask, edgecap;
  logic [1:0]       edgemode;
  logic [WIDTH-1:0] rise, fall, edge_sel, w1c;
  logic             wr;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign w1c          = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  assign irq          = |(edgecap & irqmask);
  assign unused_wdata = ^writedata;

  always_comb begin
    rise = deb & ~prev;
    fall = ~deb & prev;
    case (edgemode)
      2'b00:   edge_sel = rise;
      2'b01:   edge_sel = fall;
      2'b10:   edge_sel = rise | fall;
      default: edge_sel = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef PIO_DEBOUNCE_EN
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic [3:0]    cnt [WIDTH];

  assign tick = (presc == PW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // A level is accepted only after CNT ticks of uninterrupted difference.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (tick) begin
          if (cnt[i] == 4'(CNT - 1)) begin
            deb[i] <= sync2[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 4'd1;
          end
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb <= '0;
    end else begin
      deb <= sync2;
    end
  end
`endif

  // New edges are OR-ed in after the clear so a coincident edge wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev     <= '0;
      edgecap  <= '0;
      irqmask  <= '0;
      edgemode <= 2'b00;
      readdata <= '0;
    end else begin
      prev    <= deb;
      edgecap <= (edgecap & ~w1c) | edge_sel;
      if (wr && address == 2'd1) irqmask  <= writedata[WIDTH-1:0];
      if (wr && address == 2'd2) edgemode <= writedata[1:0];
      case (address)
        2'd0:    readdata <= 32'(deb);
        2'd1:    readdata <= 32'(irqmask);
        2'd2:    readdata <= {30'd0, edgemode};
        default: readdata <= 32'(edgecap);
      endcase
    end
  end

endmodule
